load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 34 +++
 rtl/load_store_unit.sv | 98 +++++++++
 tb/tb_load_store_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// CPU request/response, data memory handshake bundle for the load/store unit.
// slave is the unit's view; master is the CPU-plus-memory side.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_size;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_wmem;
  logic        mem_memc;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  rsp_ready, mem_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_wmem, mem_memc, mem_addr, mem_din
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output rsp_ready, mem_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_wmem, mem_memc, mem_addr, mem_din
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/word load-store unit: latency store 2, load 3, fault 1 cycle(s) to rsp_valid.
// Accepts only in IDLE; the response is held until rsp_ready, stalling new requests.
module load_store_unit #(
  parameter int ADDR_LIMIT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  load_store_unit_if.slave        lsu,
  output logic [7:0]              err_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam logic [16:0] LIMIT = 17'(ADDR_LIMIT);

  logic [1:0]  r_state;
  logic        r_we;
  logic        r_size;
  logic        r_signed;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        r_err;
  logic [7:0]  r_err_count;

  logic [16:0] w_addr_ext;
  logic [16:0] w_addr_p1;
  logic        w_fault;
  logic [7:0]  w_byte;
  logic [15:0] w_load_data;

  // 17-bit compare so that addr=0xFFFF on a word request cannot wrap to legal.
  assign w_addr_ext = {1'b0, lsu.req_addr};
  assign w_addr_p1  = w_addr_ext + 17'd1;
  assign w_fault    = lsu.req_size ? (lsu.req_addr[0] || (w_addr_p1 >= LIMIT))
                                   : (w_addr_ext >= LIMIT);

  assign w_byte      = lsu.mem_dout[7:0];
  assign w_load_data = r_size   ? lsu.mem_dout :
                       r_signed ? {{8{w_byte[7]}}, w_byte} : {8'h00, w_byte};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_size      <= 1'b0;
      r_signed    <= 1'b0;
      r_addr      <= 16'h0000;
      r_wdata     <= 16'h0000;
      r_rdata     <= 16'h0000;
      r_err       <= 1'b0;
      r_err_count <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (lsu.req_valid) begin
            r_we     <= lsu.req_we;
            r_size   <= lsu.req_size;
            r_signed <= lsu.req_signed;
            r_addr   <= lsu.req_addr;
            r_wdata  <= lsu.req_wdata;
            r_rdata  <= 16'h0000;
            r_err    <= w_fault;
            if (w_fault) begin
              r_state <= S_RESP;
              if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            end else begin
              r_state <= S_ACCESS;
            end
          end
        end
        S_ACCESS:  r_state <= r_we ? S_RESP : S_CAPTURE;
        S_CAPTURE: begin
          r_rdata <= w_load_data;
          r_state <= S_RESP;
        end
        S_RESP:    if (lsu.rsp_ready) r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // Write strobe decoded from state so an asynchronous reset removes it at once.
  assign lsu.mem_wmem  = (r_state == S_ACCESS) && r_we;
  assign lsu.mem_memc  = r_size;
  assign lsu.mem_addr  = r_addr;
  assign lsu.mem_din   = r_size ? r_wdata : {8'h00, r_wdata[7:0]};

  assign lsu.req_ready = (r_state == S_IDLE);
  assign lsu.rsp_valid = (r_state == S_RESP);
  assign lsu.rsp_rdata = r_rdata;
  assign lsu.rsp_err   = r_err;
  assign err_count     = r_err_count;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases, random traffic against a byte-array
// reference model, reset abort and error-counter saturation.
module tb_load_store_unit;
  localparam int LIMIT = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] err_count;

  load_store_unit_if bus ();

  load_store_unit #(.ADDR_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lsu       (bus.slave),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // Data memory: big-endian words, read data registered on clk.
  logic [7:0] mem     [0:LIMIT-1];
  logic [7:0] ref_mem [0:LIMIT-1];
  logic       fill_en = 1'b0;
  int         fill_idx = 0;
  logic [7:0] fill_dat = 8'h00;
  int         wmem_cnt = 0;
  int         ma;

  always @(posedge clk) begin
    ma = int'(bus.mem_addr);
    if (fill_en) begin
      mem[fill_idx] <= fill_dat;
    end else if (bus.mem_wmem === 1'b1) begin
      wmem_cnt <= wmem_cnt + 1;
      if (bus.mem_memc) begin
        if (ma < LIMIT - 1) begin
          mem[ma]     <= bus.mem_din[15:8];
          mem[ma + 1] <= bus.mem_din[7:0];
        end
      end else if (ma < LIMIT) begin
        mem[ma] <= bus.mem_din[7:0];
      end
    end
    if (bus.mem_memc) bus.mem_dout <= (ma < LIMIT - 1) ? {mem[ma], mem[ma + 1]} : 16'h0000;
    else              bus.mem_dout <= (ma < LIMIT) ? {8'h00, mem[ma]} : 16'h0000;
  end

  int          checks = 0;
  int          errors = 0;
  int          n_faults = 0;
  logic [15:0] obs_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 1);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_err"},   bus.rsp_err,   0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    chk({tag, "_mem_wmem"},  bus.mem_wmem,  0);
    chk({tag, "_mem_memc"},  bus.mem_memc,  0);
    chk({tag, "_mem_addr"},  bus.mem_addr,  0);
    chk({tag, "_mem_din"},   bus.mem_din,   0);
    chk({tag, "_err_count"}, err_count,     0);
  endtask

  // One complete transaction, called at posedge+1 with the unit idle.
  task automatic do_req(input bit we, input bit size, input bit sgn,
                        input logic [15:0] addr, input logic [15:0] wdata, input int hold);
    int          a, lat, exp_lat, wm0;
    bit          fault;
    logic [15:0] exp_rd;
    a = int'(addr);
    fault  = size ? ((a % 2) == 1 || a + 1 >= LIMIT) : (a >= LIMIT);
    exp_rd = 16'h0000;
    if (!fault && !we) begin
      if (size)                             exp_rd = 16'(int'(ref_mem[a]) * 256 + int'(ref_mem[a + 1]));
      else if (sgn && ref_mem[a] >= 8'd128) exp_rd = 16'(int'(ref_mem[a]) - 256);
      else                                  exp_rd = 16'(ref_mem[a]);
    end
    if (fault) n_faults++;
    exp_lat = fault ? 1 : (we ? 2 : 3);
    wm0 = wmem_cnt;

    chk("idle_req_ready", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    tick();
    bus.req_valid  = 1'($urandom);
    bus.req_we     = 1'($urandom);
    bus.req_size   = 1'($urandom);
    bus.req_signed = 1'($urandom);
    bus.req_addr   = 16'($urandom);
    bus.req_wdata  = 16'($urandom);

    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 8) begin
      chk("busy_req_ready", bus.req_ready, 0);
      tick();
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("rsp_err", bus.rsp_err, fault);
    chk("err_count", err_count, (n_faults > 255) ? 255 : n_faults);
    chk("wmem_pulses", wmem_cnt - wm0, (!fault && we) ? 1 : 0);
    obs_rdata = bus.rsp_rdata;

    repeat (hold) begin
      tick();
      chk("hold_rsp_valid", bus.rsp_valid, 1);
      chk("hold_rsp_rdata", bus.rsp_rdata, exp_rd);
      chk("hold_rsp_err",   bus.rsp_err,   fault);
      chk("hold_req_ready", bus.req_ready, 0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    chk("back_to_idle", bus.req_ready, 1);
    chk("rsp_dropped", bus.rsp_valid, 0);
    bus.rsp_ready = 1'b0;

    if (!fault && we) begin
      if (size) begin
        ref_mem[a]     = wdata[15:8];
        ref_mem[a + 1] = wdata[7:0];
        chk("mem_hi", mem[a + 1], ref_mem[a + 1]);
      end else begin
        ref_mem[a] = wdata[7:0];
      end
      chk("mem_lo", mem[a], ref_mem[a]);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] raddr;
    int          wm0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 1'b0; bus.req_signed = 1'b0;
    bus.req_addr = 16'h0; bus.req_wdata = 16'h0; bus.rsp_ready = 1'b0;

    #1;
    chk_reset_outputs("reset_pre_clk");

    fill_en = 1'b1;
    for (int i = 0; i < LIMIT; i++) begin
      fill_idx   = i;
      fill_dat   = 8'($urandom);
      ref_mem[i] = fill_dat;
      tick();
    end
    fill_en = 1'b0;
    chk_reset_outputs("reset_held");
    rst_n = 1'b1;
    tick();

    do_req(1'b1, 1'b1, 1'b0, 16'h0004, 16'hA55A, 0);
    chk("word_store_b4", mem[4], 8'hA5);
    chk("word_store_b5", mem[5], 8'h5A);
    do_req(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000, 0);
    chk("word_load_const", obs_rdata, 16'hA55A);

    do_req(1'b1, 1'b0, 1'b0, 16'h0007, 16'h1280, 1);
    chk("byte_store_b7", mem[7], 8'h80);
    do_req(1'b0, 1'b0, 1'b1, 16'h0007, 16'h0000, 0);
    chk("signed_byte_const", obs_rdata, 16'hFF80);
    do_req(1'b0, 1'b0, 1'b0, 16'h0007, 16'h0000, 0);
    chk("unsigned_byte_const", obs_rdata, 16'h0080);

    wm0 = wmem_cnt;
    do_req(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000, 0);
    do_req(1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 0);
    chk("fault_err_count", err_count, 2);
    chk("fault_no_write", wmem_cnt - wm0, 0);
    do_req(1'b1, 1'b1, 1'b0, 16'h003F, 16'h1234, 0);
    do_req(1'b1, 1'b1, 1'b0, 16'h003E, 16'hBEEF, 0);

    do_req(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000, 5);

    // Abort a store while its write strobe is up.
    wm0 = wmem_cnt;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 1'b1; bus.req_signed = 1'b0;
    bus.req_addr  = 16'h0010; bus.req_wdata = ~{ref_mem[16], ref_mem[17]};
    tick();
    bus.req_valid = 1'b0;
    chk("abort_wmem_up", bus.mem_wmem, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset_mid_access");
    tick();
    tick();
    chk("abort_no_write", wmem_cnt - wm0, 0);
    chk("abort_b16", mem[16], ref_mem[16]);
    chk("abort_b17", mem[17], ref_mem[17]);
    rst_n = 1'b1;
    n_faults = 0;
    tick();
    chk_reset_outputs("reset_released");

    for (int i = 0; i < 150; i++) begin
      raddr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, LIMIT + 6));
      do_req(1'($urandom), 1'($urandom), 1'($urandom), raddr, 16'($urandom),
             int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 260; i++) begin
      do_req(1'($urandom), 1'b1, 1'b0, 16'($urandom) | 16'h0001, 16'($urandom), 0);
    end
    chk("err_count_saturated", err_count, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
